// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls of configurable length, MUL/DIV freeze
// with a forced-release timeout, EX redirect flushes and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_rs1_used,
    input  logic              ifid_rs2_used,
    input  logic              ex_mdu_start,
    input  logic              mdu_done,
    input  logic              ex_redirect,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_flush,
    output logic              exmem_bubble,
    output logic              mdu_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int MCW = $clog2(MDU_LAT);

    typedef enum logic [1:0] {IDLE, LOAD_STALL, MDU_BUSY} state_t;

    state_t           state, state_nxt;
    logic [LCW-1:0]   lcnt, lcnt_nxt;
    logic [MCW-1:0]   mcnt, mcnt_nxt;
    logic             timeout_nxt;
    logic             lu_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign lu_hit = idex_memread && (idex_rd != '0) &&
                    ((ifid_rs1_used && (idex_rd == ifid_rs1)) ||
                     (ifid_rs2_used && (idex_rd == ifid_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lcnt        <= '0;
            mcnt        <= '0;
            mdu_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            lcnt        <= lcnt_nxt;
            mcnt        <= mcnt_nxt;
            mdu_timeout <= timeout_nxt;
            if (!pc_write)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    always_comb begin
        state_nxt    = state;
        lcnt_nxt     = lcnt;
        mcnt_nxt     = mcnt;
        timeout_nxt  = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;

        case (state)
            IDLE: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_mdu_start && !mdu_done) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    state_nxt    = MDU_BUSY;
                    mcnt_nxt     = MCW'(1);
                end else if (ex_mdu_start) begin
                    // MDU finished in its first cycle: nothing to hold
                    state_nxt = IDLE;
                end else if (lu_hit) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nxt = LOAD_STALL;
                        lcnt_nxt  = LCW'(LOAD_LAT - 1);
                    end
                end
            end

            LOAD_STALL: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_nxt  = IDLE;
                    lcnt_nxt   = '0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    lcnt_nxt   = lcnt - LCW'(1);
                    if (lcnt == LCW'(1))
                        state_nxt = IDLE;
                end
            end

            MDU_BUSY: begin
                if (mdu_done) begin
                    state_nxt = IDLE;
                    mcnt_nxt  = '0;
                end else begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    // Last allowed hold cycle; the timeout pulse appears with the release
                    if (mcnt == MCW'(MDU_LAT - 1)) begin
                        state_nxt   = IDLE;
                        mcnt_nxt    = '0;
                        timeout_nxt = 1'b1;
                    end else begin
                        mcnt_nxt = mcnt + MCW'(1);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (!rst_n) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ifid_flush   = 1'b0;
            idex_write   = 1'b1;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LAT=3 with a 4-bit counter, LOAD_LAT=1 default) share
// the stimulus; directed vectors push hand-computed expectations, a monitor pops and compares.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rd = '0, ifid_rs1 = '0, ifid_rs2 = '0;
    logic       ifid_rs1_used = 1'b0, ifid_rs2_used = 1'b0;
    logic       ex_mdu_start = 1'b0, mdu_done = 1'b0, ex_redirect = 1'b0;

    logic pc_a, ifw_a, iff_a, idw_a, idf_a, bub_a, tmo_a;
    logic pc_b, ifw_b, iff_b, idw_b, idf_b, bub_b, tmo_b;
    logic [3:0]  cnt_a;
    logic [31:0] cnt_b;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MDU_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rs1_used(ifid_rs1_used),
        .ifid_rs2_used(ifid_rs2_used), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .ex_redirect(ex_redirect), .pc_write(pc_a), .ifid_write(ifw_a), .ifid_flush(iff_a),
        .idex_write(idw_a), .idex_flush(idf_a), .exmem_bubble(bub_a), .mdu_timeout(tmo_a),
        .stall_cnt(cnt_a)
    );

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rs1_used(ifid_rs1_used),
        .ifid_rs2_used(ifid_rs2_used), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .ex_redirect(ex_redirect), .pc_write(pc_b), .ifid_write(ifw_b), .ifid_flush(iff_b),
        .idex_write(idw_b), .idex_flush(idf_b), .exmem_bubble(bub_b), .mdu_timeout(tmo_b),
        .stall_cnt(cnt_b)
    );

    // Output vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, mdu_timeout}
    localparam logic [6:0] NRM = 7'b1101000;
    localparam logic [6:0] LST = 7'b0001100;
    localparam logic [6:0] FLS = 7'b1111100;
    localparam logic [6:0] HLD = 7'b0000010;
    localparam logic [6:0] TMO = 7'b1101001;

    typedef struct {
        int         id;
        logic [6:0] oa;
        int         ca;
        logic [6:0] ob;
        int         cb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    task automatic cyc(input logic rn, input logic mr, input logic [4:0] rd, r1, r2,
                       input logic u1, u2, ms, md, rx,
                       input logic [6:0] ea, input int ca, input logic [6:0] eb, input int cb);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; idex_memread = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
        ifid_rs1_used = u1; ifid_rs2_used = u2;
        ex_mdu_start = ms; mdu_done = md; ex_redirect = rx;
        e.id = vec_id; e.oa = ea; e.ca = ca; e.ob = eb; e.cb = cb;
        sb.push_back(e);
        vec_id++;
    endtask

    // Monitor: outputs are settled half a cycle after inputs change
    initial begin
        exp_t e;
        logic [6:0] oa, ob;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                oa = {pc_a, ifw_a, iff_a, idw_a, idf_a, bub_a, tmo_a};
                ob = {pc_b, ifw_b, iff_b, idw_b, idf_b, bub_b, tmo_b};
                checks++;
                if (oa !== e.oa) begin
                    errors++;
                    $display("FAIL v%0d outs_a: got %b want %b", e.id, oa, e.oa);
                end
                checks++;
                if (int'(cnt_a) != e.ca) begin
                    errors++;
                    $display("FAIL v%0d stall_cnt_a: got %0d want %0d", e.id, cnt_a, e.ca);
                end
                checks++;
                if (ob !== e.ob) begin
                    errors++;
                    $display("FAIL v%0d outs_b: got %b want %b", e.id, ob, e.ob);
                end
                checks++;
                if (cnt_b != 32'(e.cb)) begin
                    errors++;
                    $display("FAIL v%0d stall_cnt_b: got %0d want %0d", e.id, cnt_b, e.cb);
                end
            end
        end
    end

    initial begin
        // rn  mr rd  r1  r2  u1 u2 ms md rx   A    ca   B    cb
        cyc(0, 1, 5,  5,  1,  1, 1, 0, 0, 0,   NRM, 0,   NRM, 0);   // in reset: lu_hit masked
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 0,   NRM, 0);
        // load-use on rs1
        cyc(1, 1, 5,  5,  1,  1, 1, 0, 0, 0,   LST, 0,   LST, 0);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   LST, 1,   NRM, 1);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   LST, 2,   NRM, 1);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 3,   NRM, 1);
        // rd==x0 and unused rs2 never stall
        cyc(1, 1, 0,  0,  0,  1, 1, 0, 0, 0,   NRM, 3,   NRM, 1);
        cyc(1, 1, 7,  3,  7,  1, 0, 0, 0, 0,   NRM, 3,   NRM, 1);
        // rs2 hit, then redirect in the 2nd stall cycle
        cyc(1, 1, 7,  3,  7,  0, 1, 0, 0, 0,   LST, 3,   LST, 1);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 1,   FLS, 4,   FLS, 2);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 4,   NRM, 2);
        // redirect beats load-use in IDLE
        cyc(1, 1, 5,  5,  1,  1, 1, 0, 0, 1,   FLS, 4,   FLS, 2);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 4,   NRM, 2);
        // MDU done on 3rd cycle; redirect/lu ignored while busy
        cyc(1, 0, 0,  0,  0,  0, 0, 1, 0, 0,   HLD, 4,   HLD, 2);
        cyc(1, 1, 5,  5,  1,  1, 1, 0, 0, 1,   HLD, 5,   HLD, 3);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 1, 0,   NRM, 6,   NRM, 4);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 6,   NRM, 4);
        // MDU done in the start cycle
        cyc(1, 0, 0,  0,  0,  0, 0, 1, 1, 0,   NRM, 6,   NRM, 4);
        // MDU timeout: 4 hold cycles then a timeout pulse
        cyc(1, 0, 0,  0,  0,  0, 0, 1, 0, 0,   HLD, 6,   HLD, 4);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   HLD, 7,   HLD, 5);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   HLD, 8,   HLD, 6);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   HLD, 9,   HLD, 7);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   TMO, 10,  TMO, 8);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 10,  NRM, 8);
        // second timeout, then load stall runs the 4-bit counter into saturation
        cyc(1, 0, 0,  0,  0,  0, 0, 1, 0, 0,   HLD, 10,  HLD, 8);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   HLD, 11,  HLD, 9);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   HLD, 12,  HLD, 10);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   HLD, 13,  HLD, 11);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   TMO, 14,  TMO, 12);
        cyc(1, 1, 5,  5,  1,  1, 1, 0, 0, 0,   LST, 14,  LST, 12);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   LST, 15,  NRM, 13);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   LST, 15,  NRM, 13);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 15,  NRM, 13);
        // reset in the middle of MDU_BUSY
        cyc(1, 0, 0,  0,  0,  0, 0, 1, 0, 0,   HLD, 15,  HLD, 13);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   HLD, 15,  HLD, 14);
        cyc(0, 0, 0,  0,  0,  0, 0, 1, 0, 0,   NRM, 0,   NRM, 0);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 0,   NRM, 0);
        cyc(1, 1, 5,  5,  1,  1, 1, 0, 0, 0,   LST, 0,   LST, 0);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   LST, 1,   NRM, 1);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   LST, 2,   NRM, 1);
        cyc(1, 0, 0,  0,  0,  0, 0, 0, 0, 0,   NRM, 3,   NRM, 1);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
